usb_link_txn_fsm: RTL and testbench

- Parametrised device-side USB 2.0 link-layer transaction controller.
- Decodes received tokens and arbitrates bus direction (d_oe), generalising the single-channel link controller to NUM_EP endpoints.
- Tracks a DATA0/DATA1 toggle per endpoint and issues ACK/NAK/STALL handshakes or IN data packets via the TX group.
- Enforces a programmable turnaround gap and receive timeout. Sits between the RX decoder/CRC checkers and the TX packet generator.

---
 rtl/usb_link_txn_fsm.sv | 191 +++++++++++++++++++
 tb/tb_usb_link_txn_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_link_txn_fsm.sv
// Device-side USB 2.0 link transaction controller: token decode, per-endpoint
// DATA0/DATA1 toggles, handshake/IN-data responses and bus direction control.
module usb_link_txn_fsm #(
    parameter int NUM_EP      = 4,
    parameter int TA_DELAY    = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        self_addr,
    output logic              d_oe,
    output logic              time_out,
    output logic              tx_start,
    output logic [1:0]        tx_type,
    output logic [3:0]        tx_pid,
    input  logic              tx_done,
    input  logic              rx_pkt_valid,
    input  logic [3:0]        rx_pid_val,
    input  logic [6:0]        rx_addr,
    input  logic [3:0]        rx_endp,
    input  logic              crc5_err,
    input  logic              crc16_err,
    input  logic [NUM_EP-1:0] ep_in_ready,
    input  logic [NUM_EP-1:0] ep_out_ready,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic [NUM_EP-1:0] toggle_clr,
    output logic [3:0]        xfer_ep,
    output logic              xfer_done,
    output logic              xfer_setup
);
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [1:0] TYPE_HS   = 2'b00;
    localparam logic [1:0] TYPE_DATA = 2'b10;
    localparam int CNT_MAX = (TIMEOUT_CYC > TA_DELAY) ? TIMEOUT_CYC : TA_DELAY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, RX_DATA, TA_WAIT, TX_DRV, TX_BUSY, WAIT_ACK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    ep_q;
    logic          setup_q;
    logic          in_data_q;
    logic [15:0]   toggle;

    // Endpoint vectors widened to 16 so a 4-bit endpoint number indexes them directly
    logic [15:0] in_rdy16, out_rdy16, stall16, clr16;
    assign in_rdy16  = 16'(ep_in_ready);
    assign out_rdy16 = 16'(ep_out_ready);
    assign stall16   = 16'(ep_stall);
    assign clr16     = 16'(toggle_clr);

    logic token_hit, is_data;
    always_comb begin
        token_hit = rx_pkt_valid && !crc5_err && (rx_addr == self_addr) &&
                    ({1'b0, rx_endp} < 5'(NUM_EP)) &&
                    ((rx_pid_val == PID_OUT) || (rx_pid_val == PID_IN) || (rx_pid_val == PID_SETUP));
        is_data   = (rx_pid_val == PID_DATA0) || (rx_pid_val == PID_DATA1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ep_q       <= '0;
            setup_q    <= 1'b0;
            in_data_q  <= 1'b0;
            toggle     <= '0;
            d_oe       <= 1'b0;
            time_out   <= 1'b0;
            tx_start   <= 1'b0;
            tx_type    <= '0;
            tx_pid     <= '0;
            xfer_ep    <= '0;
            xfer_done  <= 1'b0;
            xfer_setup <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            time_out   <= 1'b0;
            xfer_done  <= 1'b0;
            xfer_setup <= 1'b0;
            case (state)
                IDLE: begin
                    if (token_hit) begin
                        ep_q    <= rx_endp;
                        xfer_ep <= rx_endp;
                        setup_q <= (rx_pid_val == PID_SETUP);
                        cnt     <= '0;
                        if (rx_pid_val == PID_IN) begin
                            state <= TA_WAIT;
                            if (stall16[rx_endp]) begin
                                tx_type   <= TYPE_HS;
                                tx_pid    <= PID_STALL;
                                in_data_q <= 1'b0;
                            end else if (!in_rdy16[rx_endp]) begin
                                tx_type   <= TYPE_HS;
                                tx_pid    <= PID_NAK;
                                in_data_q <= 1'b0;
                            end else begin
                                tx_type   <= TYPE_DATA;
                                tx_pid    <= toggle[rx_endp] ? PID_DATA1 : PID_DATA0;
                                in_data_q <= 1'b1;
                            end
                        end else begin
                            state <= RX_DATA;
                        end
                    end
                end
                // A packet arriving on the timeout cycle takes precedence over the timeout
                RX_DATA: begin
                    if (rx_pkt_valid) begin
                        if (!is_data || crc16_err) begin
                            state <= IDLE;
                        end else begin
                            state     <= TA_WAIT;
                            cnt       <= '0;
                            tx_type   <= TYPE_HS;
                            in_data_q <= 1'b0;
                            if (setup_q) begin
                                tx_pid       <= PID_ACK;
                                xfer_done    <= 1'b1;
                                xfer_setup   <= 1'b1;
                                toggle[ep_q] <= 1'b1;
                            end else if (stall16[ep_q]) begin
                                tx_pid <= PID_STALL;
                            end else if (!out_rdy16[ep_q]) begin
                                tx_pid <= PID_NAK;
                            end else if (rx_pid_val[3] == toggle[ep_q]) begin
                                tx_pid       <= PID_ACK;
                                xfer_done    <= 1'b1;
                                toggle[ep_q] <= ~toggle[ep_q];
                            end else begin
                                tx_pid <= PID_ACK;
                            end
                        end
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        time_out <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TA_WAIT: begin
                    if (cnt == CW'(TA_DELAY - 1)) begin
                        state <= TX_DRV;
                        d_oe  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DRV: begin
                    state    <= TX_BUSY;
                    tx_start <= 1'b1;
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        d_oe  <= 1'b0;
                        cnt   <= '0;
                        state <= in_data_q ? WAIT_ACK : IDLE;
                    end
                end
                WAIT_ACK: begin
                    if (rx_pkt_valid) begin
                        state <= IDLE;
                        if (rx_pid_val == PID_ACK) begin
                            toggle[ep_q] <= ~toggle[ep_q];
                            xfer_done    <= 1'b1;
                        end
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        time_out <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Later assignment wins, giving an explicit clear priority over any flip/set
            for (int i = 0; i < 16; i++) begin
                if (clr16[i]) toggle[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_usb_link_txn_fsm.sv
// Scoreboard bench for usb_link_txn_fsm: directed host transactions push the
// expected DUT events, a negedge monitor pops and compares them as they appear.
module tb_usb_link_txn_fsm;
    localparam int NUM_EP      = 4;
    localparam int TA_DELAY    = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam logic [6:0] ADDR = 7'h2A;

    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101;
    localparam logic [3:0] P_D0 = 4'b0011, P_D1 = 4'b1011, P_ACK = 4'b0010;
    localparam logic [3:0] P_NAK = 4'b1010, P_STALL = 4'b1110;
    localparam int EV_TX = 0, EV_XFER = 1, EV_TO = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] self_addr;
    logic d_oe, time_out, tx_start, tx_done, rx_pkt_valid, crc5_err, crc16_err;
    logic [1:0] tx_type;
    logic [3:0] tx_pid, rx_pid_val, rx_endp, xfer_ep;
    logic [6:0] rx_addr;
    logic [NUM_EP-1:0] ep_in_ready, ep_out_ready, ep_stall, toggle_clr;
    logic xfer_done, xfer_setup;

    usb_link_txn_fsm #(.NUM_EP(NUM_EP), .TA_DELAY(TA_DELAY), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .self_addr(self_addr), .d_oe(d_oe), .time_out(time_out),
        .tx_start(tx_start), .tx_type(tx_type), .tx_pid(tx_pid), .tx_done(tx_done),
        .rx_pkt_valid(rx_pkt_valid), .rx_pid_val(rx_pid_val), .rx_addr(rx_addr),
        .rx_endp(rx_endp), .crc5_err(crc5_err), .crc16_err(crc16_err),
        .ep_in_ready(ep_in_ready), .ep_out_ready(ep_out_ready), .ep_stall(ep_stall),
        .toggle_clr(toggle_clr), .xfer_ep(xfer_ep), .xfer_done(xfer_done), .xfer_setup(xfer_setup)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [3:0] a;
        logic [3:0] b;
    } ev_t;
    ev_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [3:0] a, input logic [3:0] b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input string name, input int kind, input logic [3:0] a, input logic [3:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: unexpected event kind=%0d a=%0h b=%0h, none required", name, kind, a, b);
        end else begin
            e = exp_q.pop_front();
            check_output(name, {kind[7:0], a, b}, {e.kind[7:0], e.a, e.b});
        end
    endtask

    // Monitor: any DUT event must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (xfer_done) expect_ev("xfer_done", EV_XFER, {3'b000, xfer_setup}, xfer_ep);
            if (time_out)  expect_ev("time_out", EV_TO, 4'h0, 4'h0);
            if (tx_start) begin
                expect_ev("tx_start", EV_TX, {2'b00, tx_type}, tx_pid);
                check_output("d_oe_at_tx_start", {31'd0, d_oe}, 32'd1);
            end
        end
    end

    task automatic apply_stimulus(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                                  input logic c5, input logic c16);
        @(negedge clk);
        rx_pkt_valid = 1'b1; rx_pid_val = pid; rx_addr = addr; rx_endp = endp;
        crc5_err = c5; crc16_err = c16;
        @(negedge clk);
        rx_pkt_valid = 1'b0; crc5_err = 1'b0; crc16_err = 1'b0;
    endtask

    task automatic wait_drive();
        int n = 0;
        while (!d_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("ta_latency", n, TA_DELAY);
        @(negedge clk);
    endtask

    task automatic finish_tx();
        repeat (2) @(negedge clk);
        check_output("d_oe_held", {31'd0, d_oe}, 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_output("d_oe_release", {31'd0, d_oe}, 32'd0);
    endtask

    task automatic expect_quiet(input string name);
        int hi = 0;
        repeat (TA_DELAY + 6) begin
            @(negedge clk);
            if (d_oe) hi++;
        end
        check_output(name, hi, 0);
    endtask

    task automatic drain(input string name, input int cycles);
        repeat (cycles) @(negedge clk);
        check_output(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; self_addr = ADDR; tx_done = 1'b0; rx_pkt_valid = 1'b0;
        rx_pid_val = '0; rx_addr = '0; rx_endp = '0; crc5_err = 1'b0; crc16_err = 1'b0;
        ep_in_ready = 4'b0100; ep_out_ready = 4'b1111; ep_stall = 4'b0000; toggle_clr = '0;
        repeat (3) @(negedge clk);
        check_output("reset_outputs", {d_oe, time_out, tx_start, tx_type, tx_pid, xfer_ep, xfer_done, xfer_setup},
                     16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // OUT ep1 DATA0 with toggle 0: accepted
        push_ev(EV_XFER, 4'h0, 4'h1); push_ev(EV_TX, 4'h0, P_ACK);
        apply_stimulus(P_OUT, ADDR, 4'd1, 1'b0, 1'b0);
        apply_stimulus(P_D0, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        check_output("xfer_ep_out1", xfer_ep, 4'd1);
        // Duplicate DATA0: ACK only
        push_ev(EV_TX, 4'h0, P_ACK);
        apply_stimulus(P_OUT, ADDR, 4'd1, 1'b0, 1'b0);
        apply_stimulus(P_D0, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        // DATA1 now matches: accepted, toggle back to 0
        push_ev(EV_XFER, 4'h0, 4'h1); push_ev(EV_TX, 4'h0, P_ACK);
        apply_stimulus(P_OUT, ADDR, 4'd1, 1'b0, 1'b0);
        apply_stimulus(P_D1, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        // No buffer space: NAK
        ep_out_ready = 4'b1101;
        push_ev(EV_TX, 4'h0, P_NAK);
        apply_stimulus(P_OUT, ADDR, 4'd1, 1'b0, 1'b0);
        apply_stimulus(P_D0, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        ep_out_ready = 4'b1111;
        // Bad CRC16 on data: silent
        apply_stimulus(P_OUT, ADDR, 4'd1, 1'b0, 1'b0);
        apply_stimulus(P_D0, ADDR, 4'd0, 1'b0, 1'b1);
        expect_quiet("crc16_quiet");
        // OUT token then no data: timeout
        push_ev(EV_TO, 4'h0, 4'h0);
        apply_stimulus(P_OUT, ADDR, 4'd1, 1'b0, 1'b0);
        drain("rx_timeout_seen", TIMEOUT_CYC + 5);

        // IN ep2 toggle 0: DATA0, host ACK
        push_ev(EV_TX, 4'h2, P_D0);
        apply_stimulus(P_IN, ADDR, 4'd2, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        push_ev(EV_XFER, 4'h0, 4'h2);
        apply_stimulus(P_ACK, 7'h00, 4'd0, 1'b0, 1'b0);
        // IN ep2 DATA1, no ACK: timeout, toggle unchanged
        push_ev(EV_TX, 4'h2, P_D1); push_ev(EV_TO, 4'h0, 4'h0);
        apply_stimulus(P_IN, ADDR, 4'd2, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        drain("ack_timeout_seen", TIMEOUT_CYC + 5);
        push_ev(EV_TX, 4'h2, P_D1);
        apply_stimulus(P_IN, ADDR, 4'd2, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        push_ev(EV_XFER, 4'h0, 4'h2);
        apply_stimulus(P_ACK, 7'h00, 4'd0, 1'b0, 1'b0);
        // toggle 0 -> ACK sets 1 -> toggle_clr forces DATA0
        push_ev(EV_TX, 4'h2, P_D0);
        apply_stimulus(P_IN, ADDR, 4'd2, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        push_ev(EV_XFER, 4'h0, 4'h2);
        apply_stimulus(P_ACK, 7'h00, 4'd0, 1'b0, 1'b0);
        toggle_clr = 4'b0100;
        @(negedge clk);
        toggle_clr = 4'b0000;
        push_ev(EV_TX, 4'h2, P_D0);
        apply_stimulus(P_IN, ADDR, 4'd2, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        apply_stimulus(P_D0, 7'h00, 4'd0, 1'b0, 1'b0);

        // STALL and NAK responses to IN
        ep_stall = 4'b1000;
        push_ev(EV_TX, 4'h0, P_STALL);
        apply_stimulus(P_IN, ADDR, 4'd3, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        push_ev(EV_TX, 4'h0, P_NAK);
        apply_stimulus(P_IN, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive(); finish_tx();

        // Tokens that must be ignored
        apply_stimulus(P_IN, ADDR, 4'd2, 1'b1, 1'b0);
        expect_quiet("crc5_quiet");
        apply_stimulus(P_IN, 7'h15, 4'd2, 1'b0, 1'b0);
        expect_quiet("wrong_addr_quiet");
        apply_stimulus(P_IN, ADDR, 4'd4, 1'b0, 1'b0);
        expect_quiet("endp_range_quiet");

        // SETUP ignores stall and sets toggle[0]
        ep_stall = 4'b1001;
        push_ev(EV_XFER, 4'h1, 4'h0); push_ev(EV_TX, 4'h0, P_ACK);
        apply_stimulus(P_SETUP, ADDR, 4'd0, 1'b0, 1'b0);
        apply_stimulus(P_D0, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        ep_stall = 4'b1000; ep_in_ready = 4'b0101;
        push_ev(EV_TX, 4'h2, P_D1);
        apply_stimulus(P_IN, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("async_reset_d_oe", {31'd0, d_oe}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Toggles cleared by reset: DATA0 again
        push_ev(EV_TX, 4'h2, P_D0);
        apply_stimulus(P_IN, ADDR, 4'd0, 1'b0, 1'b0);
        wait_drive(); finish_tx();
        apply_stimulus(P_NAK, 7'h00, 4'd0, 1'b0, 1'b0);

        drain("scoreboard_empty", 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
